// File: rtl/mem_stage_pkg.sv
// Shared types and widths for the M stage and its data-bus sequencer.
package mem_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory access sequencer: bus handshake, timeout and sticky error.
module mem_access_fsm
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_store,
    input  logic [DATA_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_ack,
    output logic              o_req,
    output logic              o_we,
    output logic [DATA_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_stall,
    output logic              o_kill,
    output logic              o_rd_sel,
    output logic              o_bus_err
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

    mem_state_e        r_state;
    mem_state_e        w_state_nx;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_req;
    logic              r_we;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_err;

    logic w_acc;
    logic w_aligned;
    logic w_start;
    logic w_misal;
    logic w_done;
    logic w_tmo;

    assign w_acc     = i_load | i_store;
    assign w_aligned = (i_addr[1:0] == 2'b00);
    assign w_start   = (r_state == IDLE) & w_acc & w_aligned;
    assign w_misal   = (r_state == IDLE) & w_acc & ~w_aligned;
    assign w_done    = (r_state == WAIT) & i_ack;
    // A late ack on the final count still wins over the abort.
    assign w_tmo     = (r_state == WAIT) & ~i_ack & (r_cnt == TMO);

    assign o_stall   = w_start | ((r_state == WAIT) & ~i_ack & ~w_tmo);
    assign o_kill    = w_misal | w_tmo;
    assign o_rd_sel  = w_done & i_load & ~i_store;
    assign o_req     = r_req;
    assign o_we      = r_we;
    assign o_addr    = r_addr;
    assign o_wdata   = r_wdata;
    assign o_bus_err = r_err;

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            IDLE:    if (w_start) w_state_nx = WAIT;
            WAIT:    if (w_done || w_tmo) w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            if (w_start) begin
                r_cnt   <= CNT_W'(1);
                r_req   <= 1'b1;
                r_we    <= i_store;
                r_addr  <= i_addr;
                r_wdata <= i_wdata;
            end else if (w_done || w_tmo) begin
                r_cnt <= '0;
                r_req <= 1'b0;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_misal || w_tmo) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/memory_cycle.sv
// M stage: data-memory access, branch resolution and the M/W register.
module memory_cycle
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteM,
    input  logic              MemtoRegM,
    input  logic              MemWriteM,
    input  logic              BranchM,
    input  logic              ZeroM,
    input  logic [DATA_W-1:0] ALUOutM,
    input  logic [DATA_W-1:0] WriteDataM,
    input  logic [REG_W-1:0]  WriteRegM,
    input  logic [DATA_W-1:0] PCBranchM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              StallM,
    output logic              PCSrcM,
    output logic [DATA_W-1:0] PCBranchOutM,
    output logic              BusErrM,
    output logic              RegWriteW,
    output logic              MemtoRegW,
    output logic [DATA_W-1:0] ReadDataW,
    output logic [DATA_W-1:0] ALUOutW,
    output logic [REG_W-1:0]  WriteRegW
);

    logic w_stall;
    logic w_kill;
    logic w_rd_sel;

    logic              r_regwrite_w;
    logic              r_memtoreg_w;
    logic [DATA_W-1:0] r_readdata_w;
    logic [DATA_W-1:0] r_aluout_w;
    logic [REG_W-1:0]  r_writereg_w;

    mem_access_fsm #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_fsm (
        .clk       (clk),
        .rst       (rst),
        .i_load    (MemtoRegM),
        .i_store   (MemWriteM),
        .i_addr    (ALUOutM),
        .i_wdata   (WriteDataM),
        .i_ack     (dmem_ack),
        .o_req     (dmem_req),
        .o_we      (dmem_we),
        .o_addr    (dmem_addr),
        .o_wdata   (dmem_wdata),
        .o_stall   (w_stall),
        .o_kill    (w_kill),
        .o_rd_sel  (w_rd_sel),
        .o_bus_err (BusErrM)
    );

    assign StallM       = w_stall;
    assign PCSrcM       = BranchM & ZeroM;
    assign PCBranchOutM = PCBranchM;

    // Stalled cycles push a bubble; data fields keep the last result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_regwrite_w <= 1'b0;
            r_memtoreg_w <= 1'b0;
            r_readdata_w <= '0;
            r_aluout_w   <= '0;
            r_writereg_w <= '0;
        end else if (w_stall) begin
            r_regwrite_w <= 1'b0;
            r_memtoreg_w <= 1'b0;
        end else begin
            r_regwrite_w <= RegWriteM & ~w_kill;
            r_memtoreg_w <= MemtoRegM;
            r_readdata_w <= w_rd_sel ? dmem_rdata : '0;
            r_aluout_w   <= ALUOutM;
            r_writereg_w <= WriteRegM;
        end
    end

    assign RegWriteW = r_regwrite_w;
    assign MemtoRegW = r_memtoreg_w;
    assign ReadDataW = r_readdata_w;
    assign ALUOutW   = r_aluout_w;
    assign WriteRegW = r_writereg_w;

endmodule

// File: tb/tb_memory_cycle.sv
// Scoreboard bench for memory_cycle with a randomized memory responder.
module tb_memory_cycle;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteM, MemtoRegM, MemWriteM, BranchM, ZeroM;
    logic [31:0] ALUOutM, WriteDataM, PCBranchM;
    logic [4:0]  WriteRegM;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        StallM, PCSrcM, BusErrM;
    logic [31:0] PCBranchOutM;
    logic        RegWriteW, MemtoRegW;
    logic [31:0] ReadDataW, ALUOutW;
    logic [4:0]  WriteRegW;

    memory_cycle #(.TIMEOUT_CYCLES(T)) dut (
        .clk          (clk),
        .rst          (rst),
        .RegWriteM    (RegWriteM),
        .MemtoRegM    (MemtoRegM),
        .MemWriteM    (MemWriteM),
        .BranchM      (BranchM),
        .ZeroM        (ZeroM),
        .ALUOutM      (ALUOutM),
        .WriteDataM   (WriteDataM),
        .WriteRegM    (WriteRegM),
        .PCBranchM    (PCBranchM),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_ack     (dmem_ack),
        .StallM       (StallM),
        .PCSrcM       (PCSrcM),
        .PCBranchOutM (PCBranchOutM),
        .BusErrM      (BusErrM),
        .RegWriteW    (RegWriteW),
        .MemtoRegW    (MemtoRegW),
        .ReadDataW    (ReadDataW),
        .ALUOutW      (ALUOutW),
        .WriteRegW    (WriteRegW)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic        mtr;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic        err;
    } wexp_t;

    wexp_t q[$];
    wexp_t last;
    int    n_chk = 0;
    int    n_pass = 0;
    bit    mon_en = 0;
    bit    mdl_err = 0;
    bit    edge_live = 0;
    logic  edge_stall = 1'b0;

    logic [31:0] mdl_mem [logic [31:0]];
    logic [31:0] bus_mem [logic [31:0]];

    int          resp_delay = 1;
    int          wcnt = 0;
    bit          bus_expect = 0;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_wdata = '0;
    logic        exp_we = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
                      nm, act, exp, $time);
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, {31'b0, act}, {31'b0, exp});
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] mdl_rd(input logic [31:0] a);
        return mdl_mem.exists(a) ? mdl_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] bus_rd(input logic [31:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : init_word(a);
    endfunction

    // Memory responder: acks on the resp_delay-th request cycle.
    always @(posedge clk) begin
        #2;
        if (!bus_expect) chk1("no_req", dmem_req, 1'b0);
        if (dmem_req) begin
            wcnt++;
            if (bus_expect) begin
                chk("bus_addr", dmem_addr, exp_addr);
                chk1("bus_we", dmem_we, exp_we);
                chk("bus_wdata", dmem_wdata, exp_wdata);
            end
            if (wcnt == resp_delay) begin
                dmem_ack = 1'b1;
                if (dmem_we) begin
                    bus_mem[dmem_addr] = dmem_wdata;
                    dmem_rdata = $urandom;
                end else begin
                    dmem_rdata = bus_rd(dmem_addr);
                end
            end else begin
                dmem_ack   = 1'b0;
                dmem_rdata = $urandom;
            end
        end else begin
            wcnt       = 0;
            dmem_ack   = ($urandom_range(0, 3) == 0);
            dmem_rdata = $urandom;
        end
    end

    always @(posedge clk) begin
        edge_stall = StallM;
        edge_live  = mon_en && (rst === 1'b1);
    end

    always @(negedge clk) begin
        if (edge_live) begin
            if (edge_stall === 1'b0) begin
                if (q.size() == 0) begin
                    n_chk++;
                    $display("FAIL w_unexpected: W loaded with empty queue at %0t",
                             $time);
                end else begin
                    last = q.pop_front();
                    chk1("RegWriteW", RegWriteW, last.rw);
                    chk1("MemtoRegW", MemtoRegW, last.mtr);
                    chk("ReadDataW", ReadDataW, last.rd);
                    chk("ALUOutW", ALUOutW, last.alu);
                    chk("WriteRegW", 32'(WriteRegW), 32'(last.wr));
                end
            end else begin
                chk1("bubble_rw", RegWriteW, 1'b0);
                chk1("bubble_mtr", MemtoRegW, 1'b0);
                chk("hold_rd", ReadDataW, last.rd);
                chk("hold_alu", ALUOutW, last.alu);
                chk("hold_wr", 32'(WriteRegW), 32'(last.wr));
            end
            chk1("BusErrM", BusErrM, last.err);
        end
    end

    task automatic drive_nop();
        RegWriteM  = 1'b0;
        MemtoRegM  = 1'b0;
        MemWriteM  = 1'b0;
        BranchM    = 1'b0;
        ZeroM      = 1'b0;
        ALUOutM    = '0;
        WriteDataM = '0;
        WriteRegM  = '0;
        PCBranchM  = '0;
    endtask

    task automatic restart();
        q.delete();
        last    = '{rw: 1'b0, mtr: 1'b0, rd: '0, alu: '0, wr: '0, err: 1'b0};
        mdl_err = 0;
        mon_en  = 1;
    endtask

    // Entered and left one time unit after a rising edge.
    task automatic issue(input logic rw, input logic mtr, input logic mw,
                         input logic br, input logic z,
                         input logic [31:0] alu, input logic [31:0] wd,
                         input logic [31:0] pcb, input logic [4:0] wr,
                         input int d);
        wexp_t e;
        bit    acc;
        bit    aligned;
        int    stalls;
        int    exp_stalls;
        acc        = mtr | mw;
        aligned    = (alu[1:0] == 2'b00);
        e.rw       = rw;
        e.mtr      = mtr;
        e.rd       = '0;
        e.alu      = alu;
        e.wr       = wr;
        exp_stalls = 0;
        if (acc && !aligned) begin
            e.rw    = 1'b0;
            mdl_err = 1;
        end else if (acc) begin
            if (d <= T) begin
                exp_stalls = d;
                if (mw) mdl_mem[alu] = wd;
                else e.rd = mdl_rd(alu);
            end else begin
                exp_stalls = T;
                e.rw       = 1'b0;
                mdl_err    = 1;
            end
        end
        e.err = mdl_err;

        RegWriteM  = rw;
        MemtoRegM  = mtr;
        MemWriteM  = mw;
        BranchM    = br;
        ZeroM      = z;
        ALUOutM    = alu;
        WriteDataM = wd;
        WriteRegM  = wr;
        PCBranchM  = pcb;
        bus_expect = acc && aligned;
        exp_addr   = alu;
        exp_we     = mw;
        exp_wdata  = wd;
        resp_delay = d;

        stalls = 0;
        while (1) begin
            @(negedge clk);
            chk1("PCSrcM", PCSrcM, br & z);
            chk("PCBranchOutM", PCBranchOutM, pcb);
            if (StallM !== 1'b1) break;
            stalls++;
            if (stalls > T + 2) begin
                n_chk++;
                $display("FAIL stall_bound: StallM stuck high at %0t", $time);
                break;
            end
        end
        chk("stall_len", 32'(stalls), 32'(exp_stalls));
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_instr(input bit allow_err);
        int          k;
        int          d;
        logic [31:0] a;
        logic        mtr;
        logic        mw;
        k   = $urandom_range(0, 9);
        a   = 32'h100 + 32'($urandom_range(0, 7) << 2);
        d   = $urandom_range(1, 4);
        mtr = 1'b0;
        mw  = 1'b0;
        if ($urandom_range(0, 7) == 0) d = T;
        if (allow_err && $urandom_range(0, 5) == 0) d = T + 1;
        if (k <= 2) begin
            a = $urandom;
        end else if (k <= 5) begin
            mtr = 1'b1;
        end else if (k <= 7) begin
            mw = 1'b1;
        end else if (k == 8) begin
            mtr = 1'b1;
            mw  = 1'b1;
        end else begin
            mtr = 1'b1;
            if (allow_err) a = a | 32'($urandom_range(1, 3));
        end
        issue(1'($urandom_range(0, 1)), mtr, mw, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), a, $urandom, $urandom,
              5'($urandom_range(0, 31)), d);
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_req"}, dmem_req, 1'b0);
        chk1({tag, "_we"}, dmem_we, 1'b0);
        chk({tag, "_addr"}, dmem_addr, 32'h0);
        chk({tag, "_wdata"}, dmem_wdata, 32'h0);
        chk1({tag, "_buserr"}, BusErrM, 1'b0);
        chk1({tag, "_rw"}, RegWriteW, 1'b0);
        chk1({tag, "_mtr"}, MemtoRegW, 1'b0);
        chk({tag, "_rd"}, ReadDataW, 32'h0);
        chk({tag, "_alu"}, ALUOutW, 32'h0);
        chk({tag, "_wr"}, 32'(WriteRegW), 32'h0);
    endtask

    task automatic reset_mid_wait();
        RegWriteM  = 1'b1;
        MemtoRegM  = 1'b1;
        MemWriteM  = 1'b0;
        BranchM    = 1'b0;
        ZeroM      = 1'b0;
        ALUOutM    = 32'h30;
        WriteDataM = 32'h77;
        WriteRegM  = 5'd12;
        PCBranchM  = '0;
        bus_expect = 1;
        exp_addr   = 32'h30;
        exp_we     = 1'b0;
        exp_wdata  = 32'h77;
        resp_delay = 1000;
        repeat (3) @(negedge clk);
        chk1("req_before_rst", dmem_req, 1'b1);
        mon_en = 0;
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("async_rst");
        bus_expect = 0;
        drive_nop();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        restart();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        drive_nop();
        #2;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        chk1("reset_stall", StallM, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        restart();

        mdl_mem[32'h10] = 32'hDEADBEEF;
        bus_mem[32'h10] = 32'hDEADBEEF;
        issue(1, 1, 0, 0, 0, 32'h10, 32'h0, 32'h0, 5'd3, 1);
        issue(0, 0, 1, 0, 0, 32'h20, 32'h12345678, 32'h0, 5'd0, 3);
        issue(1, 1, 0, 1, 1, 32'h20, 32'h0, 32'h400, 5'd7, 2);
        issue(1, 0, 0, 0, 1, 32'hCAFE0001, 32'h5, 32'h44, 5'd9, 1);
        issue(1, 1, 0, 0, 0, 32'h24, 32'h0, 32'h0, 5'd4, T);
        issue(1, 1, 1, 0, 0, 32'h28, 32'hA5A5A5A5, 32'h0, 5'd5, 1);
        issue(1, 1, 0, 0, 0, 32'h28, 32'h0, 32'h0, 5'd6, 1);
        for (int i = 0; i < 60; i++) rand_instr(0);

        issue(1, 1, 0, 0, 0, 32'h13, 32'h0, 32'h0, 5'd8, 1);
        issue(1, 1, 0, 1, 0, 32'h40, 32'h0, 32'h0, 5'd10, T + 1);
        issue(1, 0, 0, 0, 0, 32'h99, 32'h0, 32'h0, 5'd11, 1);
        for (int i = 0; i < 60; i++) rand_instr(1);

        reset_mid_wait();
        issue(1, 1, 0, 0, 0, 32'h30, 32'h0, 32'h0, 5'd12, 1);
        for (int i = 0; i < 20; i++) rand_instr(0);
        issue(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 1);

        mon_en = 0;
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/memory_cycle.md
MEMORY_CYCLE -- requirements
Module: memory_cycle

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the number of WAIT cycles without dmem_ack before the access is aborted (legal range 2..255).
REQ-002 SHALL have ports clk (in, 1, rising-edge clock) and rst (in, 1); reset is asynchronous and active-low.
REQ-003 SHALL have inputs RegWriteM, MemtoRegM, MemWriteM, BranchM and ZeroM, each 1 bit, holding the M-stage control bits and the ALU zero flag.
REQ-004 SHALL have inputs ALUOutM (in, 32, address or ALU result), WriteDataM (in, 32, store data), WriteRegM (in, 5, destination register) and PCBranchM (in, 32, branch target).
REQ-005 SHALL have data-bus outputs dmem_req (out, 1, access request), dmem_we (out, 1, write strobe), dmem_addr (out, 32, word address) and dmem_wdata (out, 32, store data).
REQ-006 SHALL have data-bus inputs dmem_rdata (in, 32, load data) and dmem_ack (in, 1, access done, valid only while dmem_req=1).
REQ-007 SHALL have outputs StallM (out, 1, hold upstream stage), PCSrcM (out, 1, take branch), PCBranchOutM (out, 32, branch target) and BusErrM (out, 1, sticky bus error).
REQ-008 SHALL have W-stage outputs RegWriteW (1), MemtoRegW (1), ReadDataW (32), ALUOutW (32) and WriteRegW (5), all registered.

Function
REQ-009 Access: acc = MemtoRegM | MemWriteM; a load is MemtoRegM=1, a store is MemWriteM=1, and both set together is treated as a store.
REQ-010 FSM states: IDLE and WAIT.
REQ-011 IDLE with acc=1 and ALUOutM[1:0]==0: StallM=1; next state WAIT; the registered bus outputs latch the address, data and write strobe.
REQ-012 WAIT: dmem_req=1, and dmem_addr/dmem_we/dmem_wdata are held stable; StallM = ~dmem_ack.
REQ-013 WAIT with dmem_ack=1: next state IDLE; dmem_req deasserts the next cycle; the W registers load the M inputs; ReadDataW <= dmem_rdata when a load, else 0.
REQ-014 Timeout: the WAIT cycle counter starts at 1 on entry; when count==TIMEOUT_CYCLES and dmem_ack=0:
  - StallM=0 and next state IDLE;
  - BusErrM set;
  - the W registers load with RegWriteW=0 and ReadDataW=0.
REQ-015 An ack arriving on the timeout cycle takes priority over the timeout, and the access completes normally.
REQ-016 Misaligned access (acc=1, ALUOutM[1:0]!=0, IDLE):
  - no bus request; StallM=0; BusErrM set;
  - the W registers load with RegWriteW=0 and ReadDataW=0.
REQ-017 Non-access instruction (acc=0, IDLE): StallM=0; the W registers load the M inputs the next edge; ReadDataW=0; latency 1 cycle.
REQ-018 While StallM=1, the W registers load a bubble (RegWriteW=0, MemtoRegW=0); ALUOutW, WriteRegW and ReadDataW hold their values.
REQ-019 The upstream stage holds the M inputs stable while StallM=1; the block samples the M inputs only in IDLE or on the completion cycle.
REQ-020 PCSrcM = BranchM & ZeroM and PCBranchOutM = PCBranchM, both combinational and independent of StallM.
REQ-021 dmem_ack while in IDLE is ignored.
REQ-022 Minimum aligned load/store latency is 2 cycles (the IDLE request cycle plus a WAIT cycle with immediate ack); back-to-back accesses each re-enter WAIT with no idle gap.

Reset
REQ-023 rst=0 SHALL immediately force:
  - state IDLE and counter 0;
  - dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0;
  - BusErrM=0;
  - all W outputs 0.
REQ-024 Reset asserted during WAIT SHALL drop dmem_req asynchronously, and the aborted access SHALL NOT produce a W-stage write.
REQ-025 BusErrM SHALL clear only on reset.

Structure
REQ-026 A shared package mem_stage_pkg SHALL hold the state enum (IDLE, WAIT) and the constants DATA_W=32 and REG_W=5.
REQ-027 One sub-module, mem_access_fsm, SHALL own the state, the counter, the bus outputs, StallM and the error detection; memory_cycle SHALL hold the W pipeline register and the branch logic.

Verification
REQ-028 Load at ALUOutM=0x10, ack on the first WAIT cycle, dmem_rdata=0xDEADBEEF -> StallM=1 for 1 cycle, then ReadDataW=0xDEADBEEF, RegWriteW=1, MemtoRegW=1.
REQ-029 Store at 0x20 with WriteDataM=0x12345678, ack after 3 WAIT cycles -> dmem_we=1, dmem_addr=0x20, dmem_wdata stable throughout; StallM high for 3 cycles; RegWriteW=0.
REQ-030 Load with no ack and TIMEOUT_CYCLES=16 -> dmem_req drops after 16 WAIT cycles; BusErrM=1; RegWriteW=0; next state IDLE.
REQ-031 Load at 0x13 (misaligned) -> dmem_req never asserts; BusErrM=1; StallM=0; RegWriteW=0.
REQ-032 BranchM=1 and ZeroM=1 with PCBranchM=0x400 during a stalled load -> PCSrcM=1 and PCBranchOutM=0x400 in the same cycle.
REQ-033 rst=0 mid-WAIT -> dmem_req=0 with no clock edge; all outputs 0; a fresh load after release completes normally.
